// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Brief    : Opcode/ALU encodings and opcode classification for the control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    localparam int OP_NOOP = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_LDA  = 5;
    localparam int OP_STA  = 6;
    localparam int OP_JMP  = 7;
    localparam int OP_JZ   = 8;
    localparam int OP_HLT  = 9;
    localparam int NUM_OPS = 10;

    localparam int ALU_ADD = 0;
    localparam int ALU_XOR = 1;
    localparam int ALU_SUB = 2;
    localparam int ALU_AND = 3;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LDA,
        CLS_STA,
        CLS_JMP,
        CLS_JZ,
        CLS_HLT,
        CLS_ILL
    } op_class_t;

    function automatic op_class_t decode_op(input int op);
        op_class_t cls;
        case (op)
            OP_NOOP:                        cls = CLS_NOP;
            OP_ADD, OP_XOR, OP_SUB, OP_AND: cls = CLS_ALU;
            OP_LDA:                         cls = CLS_LDA;
            OP_STA:                         cls = CLS_STA;
            OP_JMP:                         cls = CLS_JMP;
            OP_JZ:                          cls = CLS_JZ;
            OP_HLT:                         cls = CLS_HLT;
            default:                        cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    function automatic int alu_code(input int op);
        int code;
        case (op)
            OP_XOR:  code = ALU_XOR;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Controller <-> datapath/memory signal bundle; master = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int OPC_W = 8,
    parameter int ALU_W = 2
);
    logic [OPC_W-1:0] opcode;
    logic             acc_zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             ld_mar;
    logic             ld_mdr;
    logic             ld_ir;
    logic             ld_acc;
    logic             ld_pc;
    logic             mar_sel;
    logic             mdr_sel;
    logic             acc_sel;
    logic             pc_sel;
    logic [ALU_W-1:0] alu_ctrl;
    logic             illegal;
    logic             halted;
    logic             fault;

    modport master (
        input  opcode, acc_zero, mem_ack,
        output mem_req, mem_we, ld_mar, ld_mdr, ld_ir, ld_acc, ld_pc,
               mar_sel, mdr_sel, acc_sel, pc_sel, alu_ctrl, illegal, halted, fault
    );

    modport slave (
        output opcode, acc_zero, mem_ack,
        input  mem_req, mem_we, ld_mar, ld_mdr, ld_ir, ld_acc, ld_pc,
               mar_sel, mdr_sel, acc_sel, pc_sel, alu_ctrl, illegal, halted, fault
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts unacknowledged request cycles; flags the last allowed one.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge i_clk) begin
                if (i_rst || clear) begin
                    r_cnt <= '0;
                end else if (count) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Fires during the MEM_TIMEOUT-th wait cycle so the FSM leaves right after it.
            assign expired = count && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle fetch/decode/execute control FSM with req/ack memory timeout.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPC_W       = 8,
    parameter int ALU_W       = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    multicycle_ctrl_if.master bus
);
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'd0,
        ST_FA    = 4'd1,
        ST_FM    = 4'd2,
        ST_FI    = 4'd3,
        ST_DEC   = 4'd4,
        ST_EA    = 4'd5,
        ST_EM    = 4'd6,
        ST_EW    = 4'd7,
        ST_SD    = 4'd8,
        ST_SM    = 4'd9,
        ST_JP    = 4'd10,
        ST_INC   = 4'd11,
        ST_HALT  = 4'd12,
        ST_FAULT = 4'd13
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    int               w_op;
    op_class_t        w_cls;
    logic             w_in_req;
    logic             w_count;
    logic             w_expired;
    logic             w_mem_req, w_mem_we, w_illegal, w_halted, w_fault;
    logic             w_ld_mar, w_ld_mdr, w_ld_ir, w_ld_acc, w_ld_pc;
    logic             w_mar_sel, w_mdr_sel, w_acc_sel, w_pc_sel;
    logic [ALU_W-1:0] w_alu_ctrl;

    // Out-of-range opcodes map to -1 so wide opcodes cannot alias a valid one.
    assign w_op     = (bus.opcode < OPC_W'(NUM_OPS)) ? int'(bus.opcode) : -1;
    assign w_cls    = decode_op(w_op);
    assign w_in_req = (r_state == ST_FM) || (r_state == ST_EM) || (r_state == ST_SM);
    assign w_count  = w_in_req && !bus.mem_ack;

    // Request states are never back to back, so clearing outside them clears on entry.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clear  (!w_in_req),
        .count  (w_count),
        .expired(w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_ld_mar     = 1'b0;
        w_ld_mdr     = 1'b0;
        w_ld_ir      = 1'b0;
        w_ld_acc     = 1'b0;
        w_ld_pc      = 1'b0;
        w_mar_sel    = 1'b0;
        w_mdr_sel    = 1'b0;
        w_acc_sel    = 1'b0;
        w_pc_sel     = 1'b0;
        w_alu_ctrl   = '0;
        w_illegal    = 1'b0;
        w_halted     = 1'b0;
        w_fault      = 1'b0;

        case (r_state)
            ST_IDLE: w_next_state = ST_FA;
            ST_FA: begin
                w_ld_mar     = 1'b1;
                w_next_state = ST_FM;
            end
            ST_FM: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ld_mdr     = 1'b1;
                    w_next_state = ST_FI;
                end else if (w_expired) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_FI: begin
                w_ld_ir      = 1'b1;
                w_next_state = ST_DEC;
            end
            ST_DEC: begin
                case (w_cls)
                    CLS_ALU, CLS_LDA, CLS_STA: w_next_state = ST_EA;
                    CLS_JMP:                   w_next_state = ST_JP;
                    CLS_JZ:                    w_next_state = bus.acc_zero ? ST_JP : ST_INC;
                    CLS_HLT:                   w_next_state = ST_HALT;
                    CLS_NOP:                   w_next_state = ST_INC;
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = ST_INC;
                    end
                endcase
            end
            ST_EA: begin
                w_ld_mar     = 1'b1;
                w_mar_sel    = 1'b1;
                w_next_state = (w_cls == CLS_STA) ? ST_SD : ST_EM;
            end
            ST_EM: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ld_mdr     = 1'b1;
                    w_next_state = ST_EW;
                end else if (w_expired) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_EW: begin
                w_ld_acc = 1'b1;
                if (w_cls == CLS_ALU) begin
                    w_acc_sel  = 1'b1;
                    w_alu_ctrl = ALU_W'(alu_code(w_op));
                end
                w_next_state = ST_INC;
            end
            ST_SD: begin
                w_ld_mdr     = 1'b1;
                w_mdr_sel    = 1'b1;
                w_next_state = ST_SM;
            end
            ST_SM: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                if (bus.mem_ack) begin
                    w_next_state = ST_INC;
                end else if (w_expired) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_JP: begin
                w_ld_pc      = 1'b1;
                w_pc_sel     = 1'b1;
                w_next_state = ST_FA;
            end
            ST_INC: begin
                w_ld_pc      = 1'b1;
                w_next_state = ST_FA;
            end
            ST_HALT:  w_halted = 1'b1;
            ST_FAULT: w_fault  = 1'b1;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign bus.mem_req  = w_mem_req;
    assign bus.mem_we   = w_mem_we;
    assign bus.ld_mar   = w_ld_mar;
    assign bus.ld_mdr   = w_ld_mdr;
    assign bus.ld_ir    = w_ld_ir;
    assign bus.ld_acc   = w_ld_acc;
    assign bus.ld_pc    = w_ld_pc;
    assign bus.mar_sel  = w_mar_sel;
    assign bus.mdr_sel  = w_mdr_sel;
    assign bus.acc_sel  = w_acc_sel;
    assign bus.pc_sel   = w_pc_sel;
    assign bus.alu_ctrl = w_alu_ctrl;
    assign bus.illegal  = w_illegal;
    assign bus.halted   = w_halted;
    assign bus.fault    = w_fault;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Scoreboard bench: instruction-level model predicts every active output cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int OPC_W   = 8;
    localparam int ALU_W   = 2;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_acc, ld_pc;
        logic       mar_sel, mdr_sel, acc_sel, pc_sel;
        logic [1:0] alu;
        logic       req, we, illegal, halted, fault;
    } vec_t;

    typedef struct {
        int   cyc;
        vec_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic armed = 1'b0;
    int   cyc = 0;
    int   t_next = 0;
    int   t_plan = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t expq[$];
    int   waitq[$];

    multicycle_ctrl_if #(.OPC_W(OPC_W), .ALU_W(ALU_W)) bus ();

    multicycle_ctrl #(
        .OPC_W      (OPC_W),
        .ALU_W      (ALU_W),
        .MEM_TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t sample();
        vec_t v;
        v = '0;
        v.ld_mar = bus.ld_mar;   v.ld_mdr  = bus.ld_mdr;  v.ld_ir   = bus.ld_ir;
        v.ld_acc = bus.ld_acc;   v.ld_pc   = bus.ld_pc;   v.mar_sel = bus.mar_sel;
        v.mdr_sel = bus.mdr_sel; v.acc_sel = bus.acc_sel; v.pc_sel  = bus.pc_sel;
        v.alu    = bus.alu_ctrl; v.req     = bus.mem_req; v.we      = bus.mem_we;
        v.illegal = bus.illegal; v.halted  = bus.halted;  v.fault   = bus.fault;
        return v;
    endfunction

    function automatic void fail(string name, string act, string exp);
        n_total++;
        $display("FAIL %s: got %s, expected %s", name, act, exp);
    endfunction

    function automatic void check(string name, bit ok, string act, string exp);
        if (ok) begin
            n_total++;
            n_pass++;
        end else begin
            fail(name, act, exp);
        end
    endfunction

    // ---------------- reference model: instruction -> timed output cycles ----------------
    function automatic void expect_at(int c, vec_t v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        expq.push_back(e);
    endfunction

    function automatic void step(vec_t v);
        expect_at(t_plan, v);
        t_plan++;
    endfunction

    function automatic logic [1:0] alu_of(int op);
        case (op)
            OP_XOR:  return 2'd1;
            OP_SUB:  return 2'd2;
            OP_AND:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // One memory access with w wait cycles; returns 0 when it times out instead.
    function automatic bit mem_access(bit we, bit load_mdr, int w);
        bit ok;
        int n;
        ok = !(TIMEOUT != 0 && w >= TIMEOUT);
        n  = ok ? w + 1 : TIMEOUT;
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v = '0;
            v.req    = 1'b1;
            v.we     = we;
            v.ld_mdr = ok && load_mdr && (i == n - 1);
            step(v);
        end
        return ok;
    endfunction

    // Returns the terminal-state output vector, or zero if the instruction retires.
    function automatic vec_t plan_instr(int op, bit accz, int w0, int w1);
        vec_t v, flt;
        flt = '0;
        flt.fault = 1'b1;
        v = '0; v.ld_mar = 1'b1; step(v);
        if (!mem_access(1'b0, 1'b1, w0)) return flt;
        v = '0; v.ld_ir = 1'b1; step(v);
        if (op > OP_HLT) begin
            v = '0; v.illegal = 1'b1; step(v);
        end else begin
            t_plan++;
        end
        case (op)
            OP_ADD, OP_XOR, OP_SUB, OP_AND, OP_LDA, OP_STA: begin
                v = '0; v.ld_mar = 1'b1; v.mar_sel = 1'b1; step(v);
                if (op == OP_STA) begin
                    v = '0; v.ld_mdr = 1'b1; v.mdr_sel = 1'b1; step(v);
                    if (!mem_access(1'b1, 1'b0, w1)) return flt;
                end else begin
                    if (!mem_access(1'b0, 1'b1, w1)) return flt;
                    v = '0; v.ld_acc = 1'b1;
                    if (op != OP_LDA) begin
                        v.acc_sel = 1'b1;
                        v.alu     = alu_of(op);
                    end
                    step(v);
                end
                v = '0; v.ld_pc = 1'b1; step(v);
            end
            OP_JMP: begin v = '0; v.ld_pc = 1'b1; v.pc_sel = 1'b1; step(v); end
            OP_JZ:  begin v = '0; v.ld_pc = 1'b1; v.pc_sel = accz; step(v); end
            OP_HLT: begin v = '0; v.halted = 1'b1; return v; end
            default: begin v = '0; v.ld_pc = 1'b1; step(v); end
        endcase
        return '0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic wait_until(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int cr);
        wait_until(cr);
        rst = 1'b1;
        wait_until(cr + 1);
        waitq.delete();
        rst = 1'b0;
        @(negedge clk);
        check("reset_idle", sample() == '0, $sformatf("vec %h", sample()), "vec 0");
        t_next = cr + 2;
    endtask

    task automatic run_instr(int op, bit accz, int w0, int w1);
        vec_t term;
        int   cr;
        wait_until(t_next);
        bus.opcode   = OPC_W'(op);
        bus.acc_zero = accz;
        waitq.push_back(w0);
        if (op >= OP_ADD && op <= OP_STA) waitq.push_back(w1);
        t_plan = t_next;
        term = plan_instr(op, accz, w0, w1);
        if (term != '0) begin
            cr = t_plan + $urandom_range(1, 4);
            for (int c = t_plan; c <= cr; c++) expect_at(c, term);
            do_reset(cr);
        end else begin
            t_next = t_plan;
        end
    endtask

    task automatic run_reset_in_fm(int n);
        vec_t v;
        wait_until(t_next);
        bus.opcode = OPC_W'($urandom_range(0, 9));
        waitq.push_back(NEVER);
        t_plan = t_next;
        v = '0; v.ld_mar = 1'b1; step(v);
        for (int i = 0; i < n; i++) begin
            v = '0; v.req = 1'b1; step(v);
        end
        do_reset(t_plan - 1);
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0:       return 13;
            1:       return 14;
            2:       return 15;
            3:       return NEVER;
            default: return $urandom_range(0, 3);
        endcase
    endfunction

    // Memory responder: acks after the queued number of wait cycles, noise when idle.
    initial begin
        int rcnt;
        int w;
        rcnt = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.mem_req) begin
                bus.mem_ack = ($urandom_range(0, 3) == 0);
                rcnt = 0;
            end else if (rst) begin
                bus.mem_ack = 1'b0;
            end else begin
                w = (waitq.size() > 0) ? waitq[0] : NEVER;
                if (rcnt >= w) begin
                    bus.mem_ack = 1'b1;
                    void'(waitq.pop_front());
                    rcnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    rcnt++;
                end
            end
        end
    end

    // Monitor: every active output cycle must match the next scoreboard entry.
    initial begin
        vec_t v;
        exp_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    fail("missing", $sformatf("nothing at cyc %0d", e.cyc), $sformatf("vec %h", e.v));
                end
                v = sample();
                if (v != '0) begin
                    if (expq.size() == 0) begin
                        fail("unexpected", $sformatf("cyc %0d vec %h", cyc, v), "no activity");
                    end else begin
                        e = expq.pop_front();
                        check("outputs", (e.cyc == cyc) && (e.v == v),
                              $sformatf("cyc %0d vec %h", cyc, v),
                              $sformatf("cyc %0d vec %h", e.cyc, e.v));
                    end
                end
            end
        end
    end

    initial begin
        int r, op;
        bus.opcode   = '0;
        bus.acc_zero = 1'b0;
        rst = 1'b1;
        wait_until(2);
        rst   = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        check("reset_idle", sample() == '0, $sformatf("vec %h", sample()), "vec 0");
        t_next = 3;

        run_instr(OP_NOOP, 1'b0, 0, 0);
        run_instr(OP_ADD,  1'b0, 2, 2);
        run_instr(OP_STA,  1'b0, 1, 0);
        run_instr(OP_JZ,   1'b1, 0, 0);
        run_instr(OP_JZ,   1'b0, 0, 0);
        run_instr(OP_JMP,  1'b0, 3, 0);
        run_instr(OP_XOR,  1'b0, 0, 1);
        run_instr(OP_SUB,  1'b1, 0, 0);
        run_instr(OP_AND,  1'b0, 1, 3);
        run_instr(OP_LDA,  1'b0, 14, 14);
        run_instr(OP_NOOP, 1'b0, NEVER, 0);
        run_instr(OP_SUB,  1'b0, 0, NEVER);
        run_instr(OP_STA,  1'b0, 0, 15);
        run_instr(255,     1'b0, 0, 0);
        run_instr(OP_HLT,  1'b0, 0, 0);
        run_reset_in_fm(5);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                run_reset_in_fm($urandom_range(1, 10));
            end else begin
                if (r < 10)      op = $urandom_range(10, 255);
                else if (r < 13) op = OP_HLT;
                else             op = $urandom_range(0, 8);
                run_instr(op, 1'(($urandom_range(0, 1))), rand_wait(), rand_wait());
            end
        end

        // Hold reset from the last retiring cycle so no new fetch starts.
        wait_until(t_next - 1);
        rst = 1'b1;
        wait_until(t_next + 3);
        @(negedge clk);
        check("final_idle", sample() == '0, $sformatf("vec %h", sample()), "vec 0");
        check("drain", expq.size() == 0, $sformatf("%0d pending", expq.size()), "0 pending");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
